// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between a division requester and seq_divider.
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   // Requester side: issues operands, observes status and results
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   // Divider side: consumes operands, produces status and results
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A zero divisor spends one extra cycle in FIN before posting its result,
// so the busy/done timing matches a one-step operation.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input logic          clk,
   input logic          rst_n,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH:0]   prem_q, prem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] work_nx;
   logic [WIDTH:0]   prem_nx;
   logic             load;

   // One restoring step: shift in the next dividend bit and try to subtract
   always_comb begin
      shifted = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
      trial   = {1'b0, shifted} - {2'b00, dvs_q};
      work_nx = {work_q[WIDTH-2:0], ~trial[WIDTH+1]};
      prem_nx = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
   end

   // Next-state, datapath and output-register logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      prem_d  = prem_q;
      dvs_d   = dvs_q;
      pend_d  = pend_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            load = bus.start;
         end
         CALC: begin
            work_d = work_nx;
            prem_d = prem_nx;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               quot_d  = work_nx;
               rem_d   = prem_nx[WIDTH-1:0];
               dbz_d   = 1'b0;
            end
         end
         FIN: begin
            if (pend_q) begin
               pend_d = 1'b0;
               busy_d = 1'b0;
               done_d = 1'b1;
               quot_d = '1;
               rem_d  = work_q;
               dbz_d  = 1'b1;
            end else begin
               load = bus.start;
               if (!bus.start) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         work_d = bus.dividend;
         dvs_d  = bus.divisor;
         prem_d = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
         if (bus.divisor != '0) begin
            state_d = CALC;
            pend_d  = 1'b0;
         end else begin
            state_d = FIN;
            pend_d  = 1'b1;
         end
      end
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         prem_q  <= '0;
         dvs_q   <= '0;
         pend_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         prem_q  <= prem_d;
         dvs_q   <= dvs_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, exhaustive WIDTH=4
// sweep and random traffic, all compared against an arithmetic model.
module tb_seq_divider;

   localparam int WIDTH = 4;

   logic clk;
   logic rst_n;
   int   nTests;
   int   nFail;
   bit   checkEn;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: counts down the operation latency and posts a/b, a%b
   logic             m_busy, m_done, m_dbz;
   logic [WIDTH-1:0] m_q, m_r;
   logic [WIDTH-1:0] p_q, p_r;
   logic             p_dbz;
   int               m_left;
   int               nAccepted;
   int               nModelDone;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_left <= 0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         m_done <= 1'b0;
         if (m_left == 1) begin
            m_busy     <= 1'b0;
            m_done     <= 1'b1;
            m_q        <= p_q;
            m_r        <= p_r;
            m_dbz      <= p_dbz;
            nModelDone <= nModelDone + 1;
         end
      end else begin
         m_done <= 1'b0;
         if (bus.start) begin
            nAccepted <= nAccepted + 1;
            m_busy    <= 1'b1;
            if (bus.divisor == '0) begin
               p_q    <= '1;
               p_r    <= bus.dividend;
               p_dbz  <= 1'b1;
               m_left <= 1;
            end else begin
               p_q    <= bus.dividend / bus.divisor;
               p_r    <= bus.dividend % bus.divisor;
               p_dbz  <= 1'b0;
               m_left <= WIDTH;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model
   int dutDones;
   always @(negedge clk) begin
      if (checkEn) begin
         nTests++;
         if (bus.done) dutDones++;
         if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !==
             {m_busy, m_done, m_q, m_r, m_dbz}) begin
            nFail++;
            $display("[TB] FAIL cycle t=%0t dut busy=%b done=%b q=%0d r=%0d dbz=%b required busy=%b done=%b q=%0d r=%0d dbz=%b",
                     $time, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
                     m_busy, m_done, m_q, m_r, m_dbz);
         end
      end
   end

   task automatic checkVal(input string name, input int act, input int exp);
      nTests++;
      if (act != exp) begin
         nFail++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Pins both the DUT and the model to hand-computed results
   task automatic checkOutput(input string name, input int q, input int r, input int dbz);
      checkVal({name, " dut.q"}, int'(bus.quotient), q);
      checkVal({name, " dut.r"}, int'(bus.remainder), r);
      checkVal({name, " dut.dbz"}, int'(bus.div_by_zero), dbz);
      checkVal({name, " model.q"}, int'(m_q), q);
      checkVal({name, " model.r"}, int'(m_r), r);
      checkVal({name, " model.dbz"}, int'(m_dbz), dbz);
   endtask

   // Presents one start across a single rising edge
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   // Bounded wait for done; reports how long and how many busy cycles
   task automatic waitDone(output int cyc, output int busyCyc);
      cyc     = 0;
      busyCyc = 0;
      while (!bus.done && cyc < 40) begin
         if (bus.busy) busyCyc++;
         @(negedge clk);
         cyc++;
      end
      if (!bus.done) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL done timeout actual=0 required=1");
      end
   endtask

   initial begin
      int cyc, bc, q, r;
      nTests       = 0;
      nFail        = 0;
      checkEn      = 1'b0;
      dutDones     = 0;
      nAccepted    = 0;
      nModelDone   = 0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_n        = 1'b0;
      #2;
      checkVal("reset busy", int'(bus.busy), 0);
      checkVal("reset done", int'(bus.done), 0);
      checkOutput("reset", 0, 0, 0);
      #20;
      rst_n = 1'b1;
      @(negedge clk);
      checkEn = 1'b1;

      applyStimulus(4'd13, 4'd3);
      waitDone(cyc, bc);
      checkVal("13/3 latency", cyc, 4);
      checkVal("13/3 busy cycles", bc, 4);
      checkOutput("13/3", 4, 1, 0);

      applyStimulus(4'd9, 4'd0);
      waitDone(cyc, bc);
      checkVal("9/0 latency", cyc, 1);
      checkVal("9/0 busy cycles", bc, 1);
      checkOutput("9/0", 15, 9, 1);
      applyStimulus(4'd15, 4'd1);
      waitDone(cyc, bc);
      checkOutput("15/1", 15, 0, 0);
      applyStimulus(4'd0, 4'd5);
      waitDone(cyc, bc);
      checkOutput("0/5", 0, 0, 0);

      applyStimulus(4'd7, 4'd2);
      waitDone(cyc, bc);
      checkOutput("7/2", 3, 1, 0);
      bus.start    = 1'b1;
      bus.dividend = 4'd14;
      bus.divisor  = 4'd7;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(cyc, bc);
      checkVal("14/7 back-to-back latency", cyc, 4);
      checkOutput("14/7", 2, 0, 0);

      applyStimulus(4'd6, 4'd3);
      bus.start    = 1'b1;
      bus.dividend = 4'd1;
      bus.divisor  = 4'd1;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(cyc, bc);
      checkOutput("6/3 ignores start in CALC", 2, 0, 0);

      applyStimulus(4'd11, 4'd4);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("abort busy", int'(bus.busy), 0);
      checkVal("abort done", int'(bus.done), 0);
      checkOutput("abort", 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkVal("abort no done", int'(bus.done), 0);
      end
      rst_n = 1'b1;
      applyStimulus(4'd11, 4'd4);
      waitDone(cyc, bc);
      checkOutput("11/4 after reset", 2, 3, 0);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            applyStimulus(WIDTH'(a), WIDTH'(b));
            waitDone(cyc, bc);
            q = int'(bus.quotient);
            r = int'(bus.remainder);
            if (b != 0) begin
               checkVal($sformatf("sweep %0d/%0d q*b+r", a, b), q * b + r, a);
               checkVal($sformatf("sweep %0d/%0d r<b", a, b), int'(r < b), 1);
            end else begin
               checkVal($sformatf("sweep %0d/0 q", a), q, 15);
               checkVal($sformatf("sweep %0d/0 r", a), r, a);
               checkVal($sformatf("sweep %0d/0 dbz", a), int'(bus.div_by_zero), 1);
            end
         end
      end

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         bus.start    = ($urandom_range(2) == 0);
         bus.dividend = WIDTH'($urandom);
         bus.divisor  = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2 * WIDTH + 4) @(negedge clk);

      checkVal("dones match model", dutDones, nModelDone);
      checkVal("dones not above accepted starts", int'(dutDones <= nAccepted), 1);

      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
